// File: rtl/i2c_target_regfile.sv
// rtl/i2c_target_regfile.sv - I2C target with a byte-addressed register file
// SCL/SDA are oversampled in soc_clk; all state advances on synchronized SCL edges.
module i2c_target_regfile #(
  parameter logic [6:0] TargetAddr = 7'h42,
  parameter int         NumRegs    = 16,
  parameter int         SyncStages = 2,
  parameter logic [7:0] RegRstVal  = 8'h00
) (
  input  logic                       soc_clk,
  input  logic                       rst_n,
  input  logic                       scl_i,
  input  logic                       sda_i,
  output logic                       sda_oe_o,
  input  logic                       host_we_i,
  input  logic [$clog2(NumRegs)-1:0] host_idx_i,
  input  logic [7:0]                 host_wdata_i,
  output logic [8*NumRegs-1:0]       regs_o,
  output logic                       i2c_wr_o,
  output logic [$clog2(NumRegs)-1:0] i2c_wr_idx_o,
  output logic                       busy_o
);
  localparam int IW = $clog2(NumRegs);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP
  } state_e;

  logic [SyncStages-1:0] scl_sync_q, sda_sync_q;
  logic                  scl_prev_q, sda_prev_q;
  logic                  scl_s, sda_s;

  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SyncStages-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SyncStages-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s = scl_sync_q[SyncStages-1];
  assign sda_s = sda_sync_q[SyncStages-1];

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & ~sda_prev_q & sda_s;

  state_e          state_q, state_d;
  logic [2:0]      bitcnt_q, bitcnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            rw_q, rw_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic            oe_q, oe_d;
  logic            busy_q, busy_d;
  logic            ackph_q, ackph_d;
  logic            wr_q, wr_d;
  logic [IW-1:0]   wr_idx_q, wr_idx_d;
  logic            i2c_we;
  logic [7:0]      regs_q [NumRegs];
  logic [7:0]      shift_in, rd_byte;
  logic            last_bit;

  assign shift_in = {shift_q[6:0], sda_s};
  assign rd_byte  = regs_q[ptr_q];
  assign last_bit = (bitcnt_q == 3'd7);

  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      rw_q     <= 1'b0;
      ptr_q    <= '0;
      oe_q     <= 1'b0;
      busy_q   <= 1'b0;
      ackph_q  <= 1'b0;
      wr_q     <= 1'b0;
      wr_idx_q <= '0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      rw_q     <= rw_d;
      ptr_q    <= ptr_d;
      oe_q     <= oe_d;
      busy_q   <= busy_d;
      ackph_q  <= ackph_d;
      wr_q     <= wr_d;
      wr_idx_q <= wr_idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    rw_d     = rw_q;
    ptr_d    = ptr_q;
    oe_d     = oe_q;
    busy_d   = busy_q;
    ackph_d  = ackph_q;
    wr_d     = 1'b0;
    wr_idx_d = wr_idx_q;
    i2c_we   = 1'b0;
    if (start_det) begin
      state_d  = ADDR;
      bitcnt_d = '0;
      busy_d   = 1'b1;
      oe_d     = 1'b0;
    end else if (stop_det) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        ADDR, PTR, WDATA: if (scl_rise) begin
          shift_d  = shift_in;
          bitcnt_d = bitcnt_q + 3'd1;
          if (last_bit) begin
            ackph_d = 1'b0;
            if (state_q == ADDR) begin
              if (shift_q[6:0] == TargetAddr) begin
                state_d = ADDR_ACK;
                rw_d    = sda_s;
              end else begin
                state_d = WAIT_STOP;
              end
            end else if (state_q == PTR) begin
              ptr_d   = shift_in[IW-1:0];
              state_d = PTR_ACK;
            end else begin
              i2c_we   = 1'b1;
              wr_d     = 1'b1;
              wr_idx_d = ptr_q;
              ptr_d    = ptr_q + IW'(1);
              state_d  = WDATA_ACK;
            end
          end
        end
        // First fall drives the ACK, second fall releases it (or starts read data).
        ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
          if (!ackph_q) begin
            oe_d    = 1'b1;
            ackph_d = 1'b1;
          end else begin
            oe_d     = 1'b0;
            bitcnt_d = '0;
            if (state_q == ADDR_ACK && rw_q) begin
              shift_d = rd_byte;
              oe_d    = ~rd_byte[7];
              state_d = RDATA;
            end else if (state_q == ADDR_ACK) begin
              state_d = PTR;
            end else begin
              state_d = WDATA;
            end
          end
        end
        RDATA: if (scl_fall) begin
          if (last_bit) begin
            oe_d    = 1'b0;
            ackph_d = 1'b0;
            state_d = RACK;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
            shift_d  = {shift_q[6:0], shift_q[7]};
            oe_d     = ~shift_q[6];
          end
        end
        RACK: begin
          if (scl_rise) begin
            if (sda_s) begin
              state_d = WAIT_STOP;
            end else begin
              ackph_d = 1'b1;
              ptr_d   = ptr_q + IW'(1);
            end
          end else if (scl_fall && ackph_q) begin
            shift_d  = rd_byte;
            oe_d     = ~rd_byte[7];
            bitcnt_d = '0;
            state_d  = RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  // Later assignment wins, so an I2C write beats a same-index host write.
  always_ff @(posedge soc_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NumRegs; k++) regs_q[k] <= RegRstVal;
    end else begin
      if (host_we_i) regs_q[host_idx_i] <= host_wdata_i;
      if (i2c_we)    regs_q[ptr_q]      <= shift_in;
    end
  end

  for (genvar k = 0; k < NumRegs; k++) begin : g_regs_o
    assign regs_o[8*k +: 8] = regs_q[k];
  end

  assign sda_oe_o     = oe_q;
  assign busy_o       = busy_q;
  assign i2c_wr_o     = wr_q;
  assign i2c_wr_idx_o = wr_idx_q;
endmodule
